// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared types and encodings for the multicycle RV32I controller.
//            The ILLEGAL state exists only when MC_ILLEGAL_TRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    , S_ILLEGAL = 4'd11
`endif
  } state_t;

  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_r    = 7'b0110011;
  localparam logic [6:0] c_op_i    = 7'b0010011;
  localparam logic [6:0] c_op_beq  = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;

  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_sub = 4'd1;
  localparam logic [3:0] c_alu_and = 4'd2;
  localparam logic [3:0] c_alu_or  = 4'd3;
  localparam logic [3:0] c_alu_xor = 4'd4;
  localparam logic [3:0] c_alu_slt = 4'd5;
  localparam logic [3:0] c_alu_sll = 4'd6;
  localparam logic [3:0] c_alu_srl = 4'd7;
  localparam logic [3:0] c_alu_sra = 4'd8;

  // ALU operation class handed to the decoder
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_a     = 2'b10;

  localparam logic [1:0] c_srcb_wd    = 2'b00;
  localparam logic [1:0] c_srcb_imm   = 2'b01;
  localparam logic [1:0] c_srcb_four  = 2'b10;

  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_data      = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      c_op_sw:  imm_src_of = c_imm_s;
      c_op_beq: imm_src_of = c_imm_b;
      c_op_jal: imm_src_of = c_imm_j;
      default:  imm_src_of = c_imm_i;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps ALU op class plus funct fields to an ALU control code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [3:0] alu_control,
  output logic       funct_illegal
);

  // funct3=011 (SLTU) is outside the supported subset
  assign funct_illegal = (funct3 == 3'b011);

  always_comb begin
    alu_control = c_alu_add;
    case (alu_op)
      c_aluop_sub: alu_control = c_alu_sub;
      c_aluop_funct: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 & funct7b5) ? c_alu_sub : c_alu_add;
          3'b001:  alu_control = c_alu_sll;
          3'b010:  alu_control = c_alu_slt;
          3'b100:  alu_control = c_alu_xor;
          3'b101:  alu_control = funct7b5 ? c_alu_sra : c_alu_srl;
          3'b110:  alu_control = c_alu_or;
          3'b111:  alu_control = c_alu_and;
          default: alu_control = c_alu_add;
        endcase
      end
      default: alu_control = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Control FSM for a multicycle RV32I core with req/ready memory.
//            Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in ILLEGAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [3:0]           alu_control,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  state_t               r_state;
  state_t               w_next_state;
  logic [INSTRET_W-1:0] r_instret;
  logic [1:0]           w_alu_op;
  logic                 w_funct_illegal;
  logic                 w_retire;
  logic                 w_mem_req;
  logic                 w_mem_write;
  logic                 w_ir_write;
  logic                 w_pc_write;
  logic                 w_reg_write;

  alu_decoder u_alu_decoder (
    .alu_op        (w_alu_op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .op_b5         (op[5]),
    .alu_control   (alu_control),
    .funct_illegal (w_funct_illegal)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic w_decode_bad;
  assign w_decode_bad = ((op == c_op_r) || (op == c_op_i)) ? w_funct_illegal :
                        !((op == c_op_lw) || (op == c_op_sw) || (op == c_op_beq) ||
                          (op == c_op_jal));
  assign illegal = (r_state == S_ILLEGAL);
`else
  logic w_unused_funct_illegal;
  assign w_unused_funct_illegal = w_funct_illegal;
  assign illegal = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
        if (w_decode_bad) w_next_state = S_ILLEGAL;
        else
`endif
        case (op)
          c_op_lw, c_op_sw: w_next_state = S_MEMADR;
          c_op_r:           w_next_state = S_EXECR;
          c_op_i:           w_next_state = S_EXECI;
          c_op_beq:         w_next_state = S_BEQ;
          c_op_jal:         w_next_state = S_JAL;
          default:          w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = (op == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = c_srca_pc;
    alu_src_b   = c_srcb_wd;
    result_src  = c_res_aluout;
    w_alu_op    = c_aluop_add;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = c_srcb_four;
        result_src = c_res_aluresult;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      // Branch target is precomputed into ALUOut while decoding
      S_DECODE: begin
        alu_src_a = c_srca_oldpc;
        alu_src_b = c_srcb_imm;
      end
      S_MEMADR: begin
        alu_src_a = c_srca_a;
        alu_src_b = c_srcb_imm;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = c_res_data;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = c_srca_a;
        alu_src_b = c_srcb_wd;
        w_alu_op  = c_aluop_funct;
      end
      S_EXECI: begin
        alu_src_a = c_srca_a;
        alu_src_b = c_srcb_imm;
        w_alu_op  = c_aluop_funct;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a  = c_srca_a;
        alu_src_b  = c_srcb_wd;
        w_alu_op   = c_aluop_sub;
        w_pc_write = zero;
      end
      // PC takes the target from ALUOut while PC+4 is formed for rd
      S_JAL: begin
        alu_src_a  = c_srca_oldpc;
        alu_src_b  = c_srcb_four;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe so an in-flight access cannot commit
  assign mem_req   = w_mem_req   & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign pc_write  = w_pc_write  & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign imm_src   = imm_src_of(op);

  assign w_retire = (r_state == S_ALUWB) || (r_state == S_MEMWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Self-checking bench; per-instruction outcome model with random
//            memory latency. MC_ILLEGAL_TRAP_EN selects trap expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam int IW = 4;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;
  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4;
  localparam int A_SLT = 5, A_SLL = 6, A_SRL = 7, A_SRA = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    op = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]    alu_src_a, alu_src_b, result_src, imm_src;
  logic [3:0]    alu_control;
  logic [IW-1:0] instret;

  int checks = 0;
  int failures = 0;
  int exp_instret = 0;
  bit rand_ready = 1'b0;
  int low_left = 0;

  multicycle_controller #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ready();
    if (low_left > 0 && mem_req === 1'b1 && adr_src === 1'b1) begin
      mem_ready = 1'b0;
      low_left--;
    end else if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    else mem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drive_ready();
    #1;
  endtask

  function automatic int ref_alu(input bit is_r, input int f3, input bit f7);
    case (f3)
      0: return (is_r && f7) ? A_SUB : A_ADD;
      1: return A_SLL;
      2: return A_SLT;
      4: return A_XOR;
      5: return f7 ? A_SRA : A_SRL;
      6: return A_OR;
      7: return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_LW: return 7'b0000011;
      K_SW: return 7'b0100011;
      K_R:  return 7'b0110011;
      K_I:  return 7'b0010011;
      K_BEQ: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  // Runs one instruction from FETCH to the next FETCH and compares its outcome
  task automatic run_instr(input int kind, input logic [6:0] opv, input int f3, input bit f7,
                           input bit z);
    int n = 0, fetch_waits = 0, data_waits = 0;
    int reg_w = 0, pc_w = 0, ir_w = 0, mw = 0, mreq = 0, a_cycles = 0, alu_seen = -1;
    int imm_bad = 0, inv_bad = 0;
    int base, exp_imm, exp_alu, retire;
    bit fetch_done = 1'b0, is_mem, writes_rd;
    op = opv; funct3 = 3'(f3); funct7b5 = f7; zero = z;
    #1;
    case (kind)
      K_LW: begin base = 5; exp_imm = 0; end
      K_SW: begin base = 4; exp_imm = 1; end
      K_R:  begin base = 4; exp_imm = -1; end
      K_I:  begin base = 4; exp_imm = 0; end
      K_BEQ: begin base = 3; exp_imm = 2; end
      K_JAL: begin base = 4; exp_imm = 3; end
      default: begin base = 2; exp_imm = -1; end
    endcase
    while (1) begin
      if (fetch_done && mem_req === 1'b1 && adr_src === 1'b0) break;
      if (n >= 40) begin
        checks++;
        failures++;
        $error("FAIL instr_timeout observed=%0d expected<40", n);
        break;
      end
      if (!fetch_done) begin
        if (mem_ready) fetch_done = 1'b1;
        else fetch_waits++;
      end else if (mem_req === 1'b1 && !mem_ready) data_waits++;
      reg_w += int'(reg_write === 1'b1);
      pc_w  += int'(pc_write === 1'b1);
      ir_w  += int'(ir_write === 1'b1);
      mw    += int'(mem_write === 1'b1);
      mreq  += int'(mem_req === 1'b1);
      if (alu_src_a === 2'b10) begin a_cycles++; alu_seen = int'(alu_control); end
      if (exp_imm >= 0 && imm_src !== 2'(exp_imm)) imm_bad++;
      if ((mem_write === 1'b1 && mem_req !== 1'b1) || illegal !== 1'b0) inv_bad++;
      tick();
      n++;
    end
    is_mem    = (kind == K_LW || kind == K_SW);
    writes_rd = (kind == K_LW || kind == K_R || kind == K_I || kind == K_JAL);
    retire    = (kind == K_BAD) ? 0 : 1;
    case (kind)
      K_R:   exp_alu = ref_alu(1'b1, f3, f7);
      K_I:   exp_alu = ref_alu(1'b0, f3, f7);
      K_BEQ: exp_alu = A_SUB;
      default: exp_alu = A_ADD;
    endcase
    check("cycles", 32'(n), 32'(base + fetch_waits + data_waits));
    check("reg_write_count", 32'(reg_w), 32'(writes_rd));
    check("pc_write_count", 32'(pc_w), 32'(1 + int'((kind == K_BEQ && z) || kind == K_JAL)));
    check("ir_write_count", 32'(ir_w), 32'd1);
    check("mem_write_cycles", 32'(mw), 32'((kind == K_SW) ? 1 + data_waits : 0));
    check("mem_req_cycles", 32'(mreq), 32'(fetch_waits + 1 + (is_mem ? 1 + data_waits : 0)));
    check("srca_a_cycles", 32'(a_cycles), 32'((kind == K_JAL || kind == K_BAD) ? 0 : 1));
    if (a_cycles == 1) check("alu_control", 32'(alu_seen), 32'(exp_alu));
    check("imm_src_errs", 32'(imm_bad), 32'd0);
    check("invariant_errs", 32'(inv_bad), 32'd0);
    exp_instret = (exp_instret + retire) % (1 << IW);
    check("instret", 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    int kind, f3;
    logic [6:0] bad_op;
    // Reset pulse: strobes masked while held, then FETCH with a ready memory
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_ready();
    #1;
    check("post_rst_mem_req", 32'(mem_req), 32'd1);
    check("post_rst_ir_write", 32'(ir_write), 32'd1);
    check("post_rst_pc_write", 32'(pc_write), 32'd1);
    check("post_rst_adr_src", 32'(adr_src), 32'd0);
    check("post_rst_instret", 32'(instret), 32'd0);
    check("post_rst_illegal", 32'(illegal), 32'd0);

    run_instr(K_LW, op_of(K_LW), 2, 1'b0, 1'b0);
    low_left = 3;
    run_instr(K_SW, op_of(K_SW), 2, 1'b0, 1'b0);
    run_instr(K_BEQ, op_of(K_BEQ), 0, 1'b0, 1'b1);
    run_instr(K_BEQ, op_of(K_BEQ), 0, 1'b0, 1'b0);
    run_instr(K_R, op_of(K_R), 0, 1'b1, 1'b0);
    run_instr(K_I, op_of(K_I), 0, 1'b1, 1'b0);
    run_instr(K_R, op_of(K_R), 5, 1'b1, 1'b0);
    run_instr(K_I, op_of(K_I), 5, 1'b0, 1'b0);
    run_instr(K_JAL, op_of(K_JAL), 0, 1'b0, 1'b0);

`ifdef MC_ILLEGAL_TRAP_EN
    op = 7'b1111111;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_ready();
    #1;
    exp_instret = 0;
    check("trap_release_instret", 32'(instret), 32'd0);
`else
    run_instr(K_BAD, 7'b1111111, 0, 1'b0, 1'b0);
    run_instr(K_R, op_of(K_R), 3, 1'b0, 1'b0);
`endif

    // Reset arriving while a load waits on memory
    op = op_of(K_LW);
    funct3 = 3'd2;
    low_left = 100;
    tick();
    tick();
    tick();
    check("midacc_mem_req", 32'({mem_req, adr_src}), 32'd3);
    rst = 1'b1;
    #1;
    check("midacc_rst_strobes",
          32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'd0);
    check("midacc_rst_instret", 32'(instret), 32'd0);
    low_left = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_ready();
    #1;
    exp_instret = 0;
    check("midacc_release_fetch", 32'({mem_req, adr_src, ir_write}), 32'b101);

    rand_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      kind = $urandom_range(0, 5);
`else
      kind = $urandom_range(0, 6);
`endif
      f3 = $urandom_range(0, 7);
`ifdef MC_ILLEGAL_TRAP_EN
      if (f3 == 3) f3 = 2;
`endif
      if (kind == K_BAD) begin
        do bad_op = 7'($urandom_range(0, 127));
        while (bad_op == 7'b0000011 || bad_op == 7'b0100011 || bad_op == 7'b0110011 ||
               bad_op == 7'b0010011 || bad_op == 7'b1100011 || bad_op == 7'b1101111);
        run_instr(kind, bad_op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        run_instr(kind, op_of(kind), f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
